// File: rtl/excess3_pkg.sv
// Shared types and constants for the serial excess-3 link.
package excess3_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int unsigned BCD_W      = 4;
  localparam logic [3:0]  XS3_OFFSET = 4'd3;
  localparam logic [3:0]  XS3_MIN    = 4'd3;
  localparam logic [3:0]  XS3_MAX    = 4'd12;

endpackage

// File: rtl/serial_borrow_cell.sv
// One bit of a ripple subtractor evaluated bit-serially.
// Ports:
//   in_bit   - minuend bit
//   s        - subtrahend bit
//   borrow   - borrow from the previous (less significant) bit
//   d        - difference bit
//   borrow_n - borrow into the next bit
module serial_borrow_cell (
  input  logic in_bit,
  input  logic s,
  input  logic borrow,
  output logic d,
  output logic borrow_n
);

  assign d        = in_bit ^ s ^ borrow;
  assign borrow_n = (~in_bit & (s | borrow)) | (s & borrow);

endmodule

// File: rtl/excess3_to_bcd_serial.sv
// Serial excess-3 to BCD decoder. Subtracts 3 from each LSB-first 4-bit digit,
// emitting the decoded bit stream, each BCD digit and the assembled frame.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   in_bit/in_valid/in_start - serial excess-3 input; in_start marks bit0/digit0
//   bit_out/bit_out_valid   - decoded bit, one cycle after the accepted input bit
//   digit_out/digit_valid/digit_error - per-digit result and invalid-code flag
//   frame_out/frame_valid/frame_error - DIGITS-digit frame, digit k at [4k+3:4k]
module excess3_to_bcd_serial
  import excess3_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_bit,
  input  logic                    in_valid,
  input  logic                    in_start,
  output logic                    bit_out,
  output logic                    bit_out_valid,
  output logic [BCD_W-1:0]        digit_out,
  output logic                    digit_valid,
  output logic                    digit_error,
  output logic [BCD_W*DIGITS-1:0] frame_out,
  output logic                    frame_valid,
  output logic                    frame_error
);

  localparam int unsigned FRAME_W = BCD_W * DIGITS;
  localparam int unsigned DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(DIGITS - 1);

  state_t               state;
  logic [1:0]           bit_cnt;
  logic [DIG_W-1:0]     dig_cnt;
  logic                 borrow;
  logic [2:0]           raw_sr;
  logic [2:0]           dec_sr;
  logic                 err_acc;
  logic [FRAME_W-1:0]   frame_acc;

  logic                 accept;
  logic                 restart;
  logic [1:0]           cur_bit;
  logic [DIG_W-1:0]     cur_dig;
  logic                 borrow_in;
  logic                 sub_bit;
  logic                 d;
  logic                 borrow_n;
  logic                 digit_end;
  logic                 frame_end;
  logic [BCD_W-1:0]     raw_code;
  logic [BCD_W-1:0]     dec_code;
  logic                 code_err;
  logic                 err_prev;
  logic [FRAME_W-1:0]   frame_next;

  // Position of the current bit; in_start forces bit0/digit0 of a new frame.
  always_comb begin
    restart   = in_valid & in_start;
    accept    = in_valid & (in_start | (state == RECV));
    cur_bit   = restart ? 2'd0 : bit_cnt;
    cur_dig   = restart ? '0 : dig_cnt;
    borrow_in = (cur_bit == 2'd0) ? 1'b0 : borrow;
    sub_bit   = XS3_OFFSET[cur_bit];
    digit_end = accept & (cur_bit == 2'd3);
    frame_end = digit_end & (cur_dig == LAST_DIG);
  end

  serial_borrow_cell u_cell (
    .in_bit   (in_bit),
    .s        (sub_bit),
    .borrow   (borrow_in),
    .d        (d),
    .borrow_n (borrow_n)
  );

  // Complete digit/frame values as seen on the bit3 cycle.
  always_comb begin
    raw_code   = {in_bit, raw_sr};
    dec_code   = {d, dec_sr};
    code_err   = (raw_code < XS3_MIN) | (raw_code > XS3_MAX);
    err_prev   = (cur_dig == '0) ? 1'b0 : err_acc;
    frame_next = frame_acc;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (cur_dig == DIG_W'(k)) frame_next[k*BCD_W +: BCD_W] = dec_code;
    end
  end

  // FSM, counters, shift registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      dig_cnt       <= '0;
      borrow        <= 1'b0;
      raw_sr        <= '0;
      dec_sr        <= '0;
      err_acc       <= 1'b0;
      frame_acc     <= '0;
      bit_out       <= 1'b0;
      bit_out_valid <= 1'b0;
      digit_out     <= '0;
      digit_valid   <= 1'b0;
      digit_error   <= 1'b0;
      frame_out     <= '0;
      frame_valid   <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      bit_out_valid <= accept;
      digit_valid   <= digit_end;
      frame_valid   <= frame_end;
      if (accept) begin
        bit_out <= d;
        borrow  <= borrow_n;
        // Shift right: after bits 0..2 the registers hold {b2,b1,b0}.
        raw_sr  <= {in_bit, raw_sr[2:1]};
        dec_sr  <= {d, dec_sr[2:1]};
        state   <= frame_end ? IDLE : RECV;
        if (digit_end) begin
          bit_cnt     <= 2'd0;
          dig_cnt     <= frame_end ? '0 : cur_dig + DIG_W'(1);
          digit_out   <= dec_code;
          digit_error <= code_err;
          err_acc     <= err_prev | code_err;
          frame_acc   <= frame_next;
        end else begin
          bit_cnt <= cur_bit + 2'd1;
          dig_cnt <= cur_dig;
        end
        if (frame_end) begin
          frame_out   <= frame_next;
          frame_error <= err_prev | code_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_excess3_to_bcd_serial.sv
// Randomized self-checking bench for excess3_to_bcd_serial against an
// arithmetic reference model (code - 3 mod 16 per digit).
module tb_excess3_to_bcd_serial;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // DIGITS=4 instance
  logic        in_bit, in_valid, in_start;
  logic        bit_out, bit_out_valid;
  logic [3:0]  digit_out;
  logic        digit_valid, digit_error;
  logic [15:0] frame_out;
  logic        frame_valid, frame_error;

  // DIGITS=1 instance
  logic        s_bit, s_valid, s_start;
  logic        s_bit_out, s_bit_out_valid;
  logic [3:0]  s_digit_out;
  logic        s_digit_valid, s_digit_error;
  logic [3:0]  s_frame_out;
  logic        s_frame_valid, s_frame_error;

  excess3_to_bcd_serial #(.DIGITS(4)) u_dut4 (
    .clock(clock), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
    .in_start(in_start), .bit_out(bit_out), .bit_out_valid(bit_out_valid),
    .digit_out(digit_out), .digit_valid(digit_valid), .digit_error(digit_error),
    .frame_out(frame_out), .frame_valid(frame_valid), .frame_error(frame_error)
  );

  excess3_to_bcd_serial #(.DIGITS(1)) u_dut1 (
    .clock(clock), .reset(reset), .in_bit(s_bit), .in_valid(s_valid),
    .in_start(s_start), .bit_out(s_bit_out), .bit_out_valid(s_bit_out_valid),
    .digit_out(s_digit_out), .digit_valid(s_digit_valid), .digit_error(s_digit_error),
    .frame_out(s_frame_out), .frame_valid(s_frame_valid), .frame_error(s_frame_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state and expectation queues
  typedef struct { logic [3:0] d; logic e; } dig_t;
  typedef struct { logic [15:0] f; logic e; } frm_t;
  logic exp_bits[$];
  dig_t exp_digs[$];
  frm_t exp_frms[$];
  bit          m_active = 0;
  int          m_bit, m_dig, m_code;
  logic [15:0] m_frame;
  logic        m_err;
  int n_bits = 0, n_digs = 0, n_frms = 0;

  task automatic model_bit(input logic b, input logic st);
    int   dec;
    dig_t dr;
    frm_t fr;
    if (st) begin
      m_active = 1; m_bit = 0; m_dig = 0; m_code = 0; m_frame = '0; m_err = 0;
    end
    if (m_active) begin
      m_code = m_code + (int'(b) << m_bit);
      // Bit k of (code-3) mod 16 depends only on code bits 0..k.
      exp_bits.push_back(1'((((m_code - 3) & 15) >> m_bit) & 1));
      m_bit++;
      if (m_bit == 4) begin
        dec  = (m_code - 3) & 15;
        dr.d = 4'(dec);
        dr.e = (m_code < 3) || (m_code > 12);
        exp_digs.push_back(dr);
        m_frame = m_frame | (16'(dec) << (4 * m_dig));
        m_err   = m_err | dr.e;
        m_code  = 0;
        m_bit   = 0;
        m_dig++;
        if (m_dig == 4) begin
          fr.f = m_frame;
          fr.e = m_err;
          exp_frms.push_back(fr);
          m_active = 0;
        end
      end
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (bit_out_valid) begin
      n_bits++;
      if (exp_bits.size() > 0) check_eq("bit_out", 32'(bit_out), 32'(exp_bits.pop_front()));
      else check_eq("bit_unexpected", 32'(bit_out_valid), 0);
    end
    if (digit_valid) begin
      dig_t dr;
      n_digs++;
      if (exp_digs.size() > 0) begin
        dr = exp_digs.pop_front();
        check_eq("digit_out", 32'(digit_out), 32'(dr.d));
        check_eq("digit_error", 32'(digit_error), 32'(dr.e));
      end else check_eq("digit_unexpected", 32'(digit_valid), 0);
    end
    if (frame_valid) begin
      frm_t fr;
      n_frms++;
      check_eq("frame_with_digit", 32'(digit_valid), 1);
      if (exp_frms.size() > 0) begin
        fr = exp_frms.pop_front();
        check_eq("frame_out", 32'(frame_out), 32'(fr.f));
        check_eq("frame_error", 32'(frame_error), 32'(fr.e));
      end else check_eq("frame_unexpected", 32'(frame_valid), 0);
    end
  end

  task automatic idle(input int n);
    in_valid = 0; in_start = 0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send_bit(input logic b, input logic st, input int gap);
    idle(gap);
    in_bit = b; in_valid = 1; in_start = st;
    model_bit(b, st);
    @(posedge clock); #1;
    in_valid = 0; in_start = 0;
  endtask

  task automatic send_frame(input int codes[4], input int max_gap);
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 4; k++)
        send_bit(1'((codes[d] >> k) & 1), (d == 0) && (k == 0),
                 (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic do_reset();
    reset = 1; m_active = 0;
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    check_eq("rst_dut4", {6'd0, bit_out, bit_out_valid, digit_out, digit_valid,
                          digit_error, frame_out, frame_valid, frame_error}, 0);
    check_eq("rst_dut1", {22'd0, s_bit_out, s_bit_out_valid, s_digit_out, s_digit_valid,
                          s_digit_error, s_frame_out, s_frame_valid, s_frame_error}, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    int          b0, d0, f0;
    int          rc[4];
    logic [3:0]  t1_exp;

    in_bit = 0; in_valid = 0; in_start = 0;
    s_bit = 0; s_valid = 0; s_start = 0;
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Single-digit instance: code 0111 decodes to 0100
    t1_exp = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      s_bit = 1'((7 >> i) & 1); s_valid = 1; s_start = (i == 0);
      @(posedge clock); #1;
      s_valid = 0; s_start = 0;
      @(negedge clock);
      check_eq("t1_bit_valid", 32'(s_bit_out_valid), 1);
      check_eq("t1_bit", 32'(s_bit_out), 32'(t1_exp[i]));
      if (i == 3) begin
        check_eq("t1_digit_valid", 32'(s_digit_valid), 1);
        check_eq("t1_digit_out", 32'(s_digit_out), 4);
        check_eq("t1_digit_error", 32'(s_digit_error), 0);
        check_eq("t1_frame_valid", 32'(s_frame_valid), 1);
        check_eq("t1_frame_out", 32'(s_frame_out), 4);
      end
    end
    @(posedge clock); #1;

    // Back-to-back valid frame
    d0 = n_digs; f0 = n_frms;
    send_frame('{6, 12, 3, 8}, 0);
    idle(3);
    check_eq("t2_frame_out", 32'(frame_out), 32'h5093);
    check_eq("t2_frame_error", 32'(frame_error), 0);
    check_eq("t2_digit_pulses", 32'(n_digs - d0), 4);
    check_eq("t2_frame_pulses", 32'(n_frms - f0), 1);

    // Out-of-range codes 0000 and 1111
    send_frame('{0, 15, 5, 7}, 0);
    idle(3);
    check_eq("t3_frame_error", 32'(frame_error), 1);
    check_eq("t3_frame_out", 32'(frame_out), 32'h42CD);

    // Same as test 2 with random stalls
    b0 = n_bits; f0 = n_frms;
    send_frame('{6, 12, 3, 8}, 5);
    idle(3);
    check_eq("t4_bit_pulses", 32'(n_bits - b0), 16);
    check_eq("t4_frame_out", 32'(frame_out), 32'h5093);
    check_eq("t4_frame_error", 32'(frame_error), 0);
    check_eq("t4_frame_pulses", 32'(n_frms - f0), 1);

    // in_start reasserted at bit2 of digit1
    f0 = n_frms;
    for (int k = 0; k < 4; k++) send_bit(1'((6 >> k) & 1), k == 0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    send_frame('{4, 5, 6, 7}, 0);
    idle(3);
    check_eq("t5_frame_pulses", 32'(n_frms - f0), 1);
    check_eq("t5_frame_out", 32'(frame_out), 32'h4321);

    // Reset at bit1 of digit2, then unstarted bits are ignored
    for (int k = 0; k < 4; k++) send_bit(1'((5 >> k) & 1), k == 0, 0);
    for (int k = 0; k < 4; k++) send_bit(1'((10 >> k) & 1), 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    do_reset();
    b0 = n_bits;
    for (int k = 0; k < 4; k++) send_bit(1'(k & 1), 1'b0, 0);
    idle(2);
    check_eq("t6_ignored_bits", 32'(n_bits - b0), 0);
    send_frame('{9, 3, 12, 4}, 2);
    idle(3);
    check_eq("t6_frame_out", 32'(frame_out), 32'h1906);

    // Random frames with random stalls
    for (int f = 0; f < 20; f++) begin
      for (int d = 0; d < 4; d++) rc[d] = int'($urandom_range(0, 15));
      send_frame(rc, 3);
      idle(int'($urandom_range(0, 2)));
    end
    idle(5);
    check_eq("end_bits_pending", 32'(exp_bits.size()), 0);
    check_eq("end_digits_pending", 32'(exp_digs.size()), 0);
    check_eq("end_frames_pending", 32'(exp_frms.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
